// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the push-button conditioners.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } key_state_t;

    localparam int unsigned DEB_20MS_50MHZ = 1_000_000;
    localparam int unsigned LONG_2S_50MHZ  = 100_000_000;

endpackage

// File: rtl/key_conditioner_if.sv
// Key pin in, debounced level and event pulses out.
interface key_conditioner_if;

    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output key_n,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  key_n,
        output key_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );

endinterface

// File: rtl/key_conditioner_sync_2ff.sv
// Two-flop synchroniser with a selectable reset value; shared by keys and switches.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Synchronises and debounces one active-low key; emits level plus press/release/long pulses.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
    parameter int unsigned LONG_CYCLES     = LONG_2S_50MHZ
) (
    input  logic             clk,
    input  logic             reset,
    key_conditioner_if.slave kif
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              key_sync_n;
    logic              key_sync;
    key_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kif.key_n),
        .q     (key_sync_n)
    );

    assign key_sync = ~key_sync_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (!key_sync) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                // hold_cnt stops at LONG_CYCLES-1 once fired, so it never wraps
                if (!key_sync) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end else if (!long_done_q) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            RELEASE_DB: begin
                if (key_sync) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign kif.key_level     = level_q;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.long_pulse    = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table, corner sequences and random stimulus vs a run-length model.
module tb_key_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: debounced level flips after D+1 consecutive disagreeing samples.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0, m_done = 1'b0;
    int   m_run = 0, m_hcnt = 0;

    logic o_level, o_press, o_rel, o_long;

    // Play/pause toggle fed by key_level rising edges.
    logic running, prev_lvl;
    always @(posedge clk) begin
        if (!reset) begin
            running  <= 1'b0;
            prev_lvl <= 1'b0;
        end else begin
            prev_lvl <= kif.key_level;
            if (kif.key_level && !prev_lvl) running <= ~running;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic kn, input logic rst);
        logic ks;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_level = 1'b0; m_run = 0; m_hcnt = 0; m_done = 1'b0;
        end else begin
            ks   = ~m_s2;
            m_s2 = m_s1;
            m_s1 = kn;
            if (ks != m_level) begin
                m_run++;
                if (m_run == int'(D) + 1) begin
                    m_level = ks;
                    m_run   = 0;
                    if (ks) begin
                        m_press = 1'b1;
                        m_hcnt  = 0;
                        m_done  = 1'b0;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                // a steady pressed sample counts only if the previous one was steady too
                if (m_level && m_run == 0 && !m_done) begin
                    m_hcnt++;
                    if (m_hcnt == int'(L)) begin
                        m_long = 1'b1;
                        m_done = 1'b1;
                    end
                end
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic kn, input logic rst);
        kif.key_n = kn;
        reset     = rst;
        @(posedge clk);
        model_update(kn, rst);
        #1;
        o_level = kif.key_level;
        o_press = kif.press_pulse;
        o_rel   = kif.release_pulse;
        o_long  = kif.long_pulse;
        check1("model_level",   o_level, m_level);
        check1("model_press",   o_press, m_press);
        check1("model_release", o_rel,   m_rel);
        check1("model_long",    o_long,  m_long);
    endtask

    typedef struct {
        int   n;
        logic kn;
        logic rst;
        logic lvl;
        logic pr;
        logic rl;
        logic lg;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pe, le, lc, re, rc, lo, pi;
        logic kn;

        // Reset, clean press/release, 3x bounce, then a second clean press/release.
        tbl.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            tbl.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
            tbl.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        tbl.push_back('{6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (tbl[v]) begin
            for (int j = 0; j < tbl[v].n; j++) begin
                step(tbl[v].kn, tbl[v].rst);
                check1("tbl_level",   o_level, tbl[v].lvl);
                check1("tbl_press",   o_press, tbl[v].pr);
                check1("tbl_release", o_rel,   tbl[v].rl);
                check1("tbl_long",    o_long,  tbl[v].lg);
            end
        end

        // Long press: one long_pulse exactly L cycles after press_pulse.
        pe = -1; le = -1; lc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
            if (o_press && pe < 0) pe = i;
            if (o_long) begin lc++; le = i; end
        end
        checkint("long_press_edge", pe, int'(D) + 2);
        checkint("long_count", lc, 1);
        checkint("long_gap", le - pe, int'(L));
        check1("long_level_held", o_level, 1'b1);
        re = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1);
            if (o_rel && re < 0) re = i;
        end
        checkint("long_release_edge", re, int'(D) + 2);
        check1("long_level_after", o_level, 1'b0);

        // Release glitch of 2 samples: long_pulse delayed by 3, no release activity.
        pe = -1; le = -1; rc = 0; lo = 0;
        for (int i = 0; i < 60; i++) begin
            kn = (i == 12 || i == 13) ? 1'b1 : 1'b0;
            step(kn, 1'b1);
            if (o_press && pe < 0) pe = i;
            if (o_long && le < 0) le = i;
            if (o_rel) rc++;
            if (pe >= 0 && !o_level) lo++;
        end
        checkint("glitch_long_gap", le - pe, int'(L) + 3);
        checkint("glitch_release", rc, 0);
        checkint("glitch_level_drop", lo, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        // Reset while held: outputs clear, fresh press D+3 edges after the reset edge.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check1("rst_level", o_level, 1'b0);
        check1("rst_press", o_press, 1'b0);
        check1("rst_release", o_rel, 1'b0);
        check1("rst_long", o_long, 1'b0);
        pi = -1;
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b1);
            if (o_press && pi < 0) pi = i;
        end
        checkint("rst_repress_edge", pi, int'(D) + 3);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        // Integration: play/pause toggles once per accepted press despite bounce.
        step(1'b1, 1'b0);
        check1("toggle_reset", running, 1'b0);
        for (int p = 0; p < 2; p++) begin
            step(1'b0, 1'b1); step(1'b1, 1'b1);
            for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
            step(1'b1, 1'b1); step(1'b0, 1'b1);
            for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
            check1(p == 0 ? "toggle_first" : "toggle_second", running, (p == 0) ? 1'b1 : 1'b0);
        end

        // Random key activity with occasional resets.
        for (int r = 0; r < 250; r++) begin
            int len;
            kn  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40))
                                              : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++)
                step(kn, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
